dmem_write_arbiter: RTL and testbench
=====================================

Name: dmem_write_arbiter

Overview:
- Owns the single write port of the 256x8 data memory. Shares it between three requesters: the pipeline store from EX, the switch loader, and a block-clear/fill engine.
- Pipeline stores never stall. Switch writes wait in a one-entry holding register. The fill engine uses only cycles left idle by the other two.
- Drives registered write enable, address and data to the memory, so the write lands one cycle after the requester wins arbitration.

Parameters:
- AW, 8, address width; memory depth is 2**AW.
- DW, 8, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- pipe_we  in  1  pipeline store request, single-cycle qualified.
- pipe_addr  in  AW  pipeline store address.
- pipe_data  in  DW  pipeline store data.
- sw_req  in  1  switch write request, level; edge-detected internally.
- sw_addr  in  AW  switch write address.
- sw_data  in  DW  switch write data.
- sw_pending  out  1  holding register occupied.
- sw_ack  out  1  one-cycle pulse, same cycle the switch write is driven on mem_we.
- sw_overflow  out  1  sticky; a new switch request edge arrived while a switch write was pending. Cleared only by rst.
- clr_start  in  1  start a fill, sampled only in IDLE.
- clr_base  in  AW  first fill address.
- clr_len  in  AW  fill length; 0 means 2**AW words.
- clr_value  in  DW  fill data.
- clr_busy  out  1  fill engine not in IDLE.
- clr_done  out  1  one-cycle pulse after the last fill word is written.
- mem_we  out  1  registered memory write enable.
- mem_addr  out  AW  registered memory write address.
- mem_data  out  DW  registered memory write data.

Behaviour:
- Reset: all outputs 0; holding register empty; sw_req edge register 0; FSM in IDLE; counters 0. rst wins over every other input.
- A reset mid-fill aborts the fill. No clr_done is issued, and no pending write is issued after reset.
- Switch capture:
  - sw_rise = sw_req & ~sw_req_q.
  - On sw_rise with the holding register empty, latch sw_addr/sw_data and set sw_pending.
  - On sw_rise with the holding register full, drop the request and set sw_overflow.
  - Same-cycle issue plus new rise: the old entry issues and the new entry is captured. No overflow.
- Arbitration is evaluated every cycle in fixed priority: pipe_we > sw_pending > fill engine in RUN.
  - The winner's addr/data are registered into mem_addr/mem_data and mem_we=1 on the next edge.
  - With no winner, mem_we=0 and mem_addr/mem_data hold their last values.
- A switch write clears sw_pending on the same edge that sets mem_we.
  - sw_ack is registered alongside mem_we, so it is high exactly in the cycle mem_we carries the switch write.
- A losing requester holds its state; nothing is lost except on overflow.
- Fill FSM states: IDLE, RUN, DONE.
  - IDLE: on clr_start, latch base into addr counter, len into remaining counter (0 is loaded as 2**AW, stored in AW+1 bits), and value. Go to RUN.
  - RUN: on each cycle the engine wins, issue (addr, value), addr+1 wrapping 2**AW-1 -> 0, remaining-1. When the issued word was the last one (remaining==1), go to DONE.
  - DONE: one cycle. clr_done=1, coincident with mem_we of the last fill word. Then go to IDLE.
- clr_busy=1 in RUN and DONE.
- clr_start outside IDLE is ignored; parameters are not re-latched.
- Latency: request-to-mem_we is 1 cycle when uncontended. A fill of N uncontended words takes N cycles of RUN; clr_done is in cycle N+1 after start.

Decomposition:
- Shared package (dmem_pkg) holds:
  - AW/DW defaults
  - fill FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - requester-select encoding: SEL_NONE, SEL_PIPE, SEL_SW, SEL_FILL
- One natural sub-module: dmem_fill_engine, containing the FSM, address/remaining counters and fill value latch, exposing fill_req/fill_addr/fill_data/fill_grant.
- The arbiter top keeps switch capture, priority mux and output registers.

Test Plan:
- Reset: rst high 2 cycles while pipe_we=1, sw_req=1 and clr_start=1. Required: mem_we=0, sw_pending=0, clr_busy=0, sw_overflow=0 throughout. First activity appears no earlier than 1 cycle after rst falls.
- Pipeline priority: pipe_we with addr 8'h10, data 8'hAA in the same cycle as sw_req rise with addr 8'h20, data 8'h55. Required:
  - cycle+1: mem_we=1, mem_addr=8'h10, mem_data=8'hAA, sw_pending=1.
  - cycle+2: mem_addr=8'h20, mem_data=8'h55, sw_ack=1.
- Overflow: pipe_we held high 4 cycles, sw_req pulses at cycle 0 (addr 1, data 8'h11) and cycle 2 (addr 2, data 8'h22). Required:
  - sw_overflow=1 from cycle 3.
  - Only the 8'h01/8'h11 write issues, in the cycle after pipe_we drops.
- Fill wrap: clr_base=8'hFE, clr_len=3, clr_value=8'h5A, clr_start pulse. Required:
  - Writes to FE, FF, 00 on 3 consecutive cycles.
  - clr_done pulses with the 00 write.
  - clr_busy low the following cycle.
- Fill preemption and full length: clr_len=0, base 0. pipe_we asserted for 2 cycles mid-fill, and clr_start re-pulsed during RUN. Required:
  - 256 fill writes, addresses 0..255 each once, with a 2-cycle gap filled by the pipeline writes.
  - The restart is ignored.
  - clr_done after 258 busy cycles.
- Reset mid-fill: rst asserted after 5 fill words. Required:
  - No further writes.
  - No clr_done.
  - A new clr_start after reset restarts cleanly from its new base.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory write arbiter: default widths, fill FSM
// state encoding and the requester-select code used by the priority mux.
package dmem_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_SW   = 2'd2,
    SEL_FILL = 2'd3
  } sel_t;
endpackage

// File: rtl/dmem_write_arbiter_if.sv
// Requester/memory-side signal bundle of the write arbiter; master is the
// requester side (pipeline, switch loader, fill control), slave is the arbiter.
interface dmem_write_arbiter_if
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          sw_req;
  logic [AW-1:0] sw_addr;
  logic [DW-1:0] sw_data;
  logic          sw_pending;
  logic          sw_ack;
  logic          sw_overflow;
  logic          clr_start;
  logic [AW-1:0] clr_base;
  logic [AW-1:0] clr_len;
  logic [DW-1:0] clr_value;
  logic          clr_busy;
  logic          clr_done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output sw_req, sw_addr, sw_data,
    output clr_start, clr_base, clr_len, clr_value,
    input  sw_pending, sw_ack, sw_overflow, clr_busy, clr_done,
    input  mem_we, mem_addr, mem_data
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  sw_req, sw_addr, sw_data,
    input  clr_start, clr_base, clr_len, clr_value,
    output sw_pending, sw_ack, sw_overflow, clr_busy, clr_done,
    output mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/dmem_fill_engine.sv
// Block clear/fill engine: walks addr/remaining counters, one word per granted cycle.
// Never stalls others; when not granted it simply holds and retries next cycle.
module dmem_fill_engine
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  input  logic [AW-1:0] clr_base,
  input  logic [AW-1:0] clr_len,
  input  logic [DW-1:0] clr_value,
  input  logic          fill_grant,
  output logic          fill_req,
  output logic [AW-1:0] fill_addr,
  output logic [DW-1:0] fill_data,
  output logic          clr_busy,
  output logic          clr_done
);
  localparam logic [AW:0] REM_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] REM_ONE  = {{AW{1'b0}}, 1'b1};

  fill_state_t   r_state;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_rem;
  logic [DW-1:0] r_value;
  logic          r_busy;
  logic          r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_value <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        FILL_IDLE: begin
          r_done <= 1'b0;
          if (clr_start) begin
            r_addr  <= clr_base;
            // zero length means the whole memory
            r_rem   <= (clr_len == '0) ? REM_FULL : {1'b0, clr_len};
            r_value <= clr_value;
            r_busy  <= 1'b1;
            r_state <= FILL_RUN;
          end
        end
        FILL_RUN: begin
          if (fill_grant) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == REM_ONE) begin
              r_done  <= 1'b1;
              r_state <= FILL_DONE;
            end
          end
        end
        FILL_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= FILL_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= FILL_IDLE;
        end
      endcase
    end
  end

  assign fill_req  = (r_state == FILL_RUN);
  assign fill_addr = r_addr;
  assign fill_data = r_value;
  assign clr_busy  = r_busy;
  assign clr_done  = r_done;
endmodule

// File: rtl/dmem_write_arbiter.sv
// Single write port of the data memory: priority pipe > switch > fill, registered out.
// Latency 1 cycle; pipe never stalls, switch waits in one holding entry, fill uses idle cycles.
module dmem_write_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic                clk,
  input logic                rst,
  dmem_write_arbiter_if.slave bus
);
  logic          r_sw_req_q;
  logic          r_sw_pend;
  logic          r_sw_ovf;
  logic          r_sw_ack;
  logic [AW-1:0] r_sw_addr;
  logic [DW-1:0] r_sw_data;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_data;

  logic          w_sw_rise;
  logic          w_sw_issue;
  logic          w_fill_req;
  logic          w_fill_grant;
  logic [AW-1:0] w_fill_addr;
  logic [DW-1:0] w_fill_data;
  sel_t          w_sel;

  assign w_sw_rise = bus.sw_req & ~r_sw_req_q;

  always_comb begin
    w_sel = SEL_NONE;
    if (bus.pipe_we)  w_sel = SEL_PIPE;
    else if (r_sw_pend) w_sel = SEL_SW;
    else if (w_fill_req) w_sel = SEL_FILL;
  end

  assign w_sw_issue   = (w_sel == SEL_SW);
  assign w_fill_grant = (w_sel == SEL_FILL);

  dmem_fill_engine #(.AW(AW), .DW(DW)) u_fill (
    .clk        (clk),
    .rst        (rst),
    .clr_start  (bus.clr_start),
    .clr_base   (bus.clr_base),
    .clr_len    (bus.clr_len),
    .clr_value  (bus.clr_value),
    .fill_grant (w_fill_grant),
    .fill_req   (w_fill_req),
    .fill_addr  (w_fill_addr),
    .fill_data  (w_fill_data),
    .clr_busy   (bus.clr_busy),
    .clr_done   (bus.clr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_req_q <= 1'b0;
      r_sw_pend  <= 1'b0;
      r_sw_ovf   <= 1'b0;
      r_sw_addr  <= '0;
      r_sw_data  <= '0;
      r_sw_ack   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_sw_req_q <= bus.sw_req;
      // an entry leaving this cycle frees the slot for a simultaneous new rise
      if (w_sw_rise && (!r_sw_pend || w_sw_issue)) begin
        r_sw_pend <= 1'b1;
        r_sw_addr <= bus.sw_addr;
        r_sw_data <= bus.sw_data;
      end else if (w_sw_rise) begin
        r_sw_ovf  <= 1'b1;
      end else if (w_sw_issue) begin
        r_sw_pend <= 1'b0;
      end

      r_sw_ack <= w_sw_issue;
      case (w_sel)
        SEL_PIPE: begin
          r_mem_we   <= 1'b1;
          r_mem_addr <= bus.pipe_addr;
          r_mem_data <= bus.pipe_data;
        end
        SEL_SW: begin
          r_mem_we   <= 1'b1;
          r_mem_addr <= r_sw_addr;
          r_mem_data <= r_sw_data;
        end
        SEL_FILL: begin
          r_mem_we   <= 1'b1;
          r_mem_addr <= w_fill_addr;
          r_mem_data <= w_fill_data;
        end
        default: r_mem_we <= 1'b0;
      endcase
    end
  end

  assign bus.sw_pending  = r_sw_pend;
  assign bus.sw_overflow = r_sw_ovf;
  assign bus.sw_ack      = r_sw_ack;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data    = r_mem_data;
endmodule

// File: tb/tb_dmem_write_arbiter.sv
// Directed bench: stimulus pushes expected memory writes, a negedge monitor pops and compares.
module tb_dmem_write_arbiter;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       ack;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];
  exp_t mon_exp;
  exp_t mon_got;

  dmem_write_arbiter_if #(.AW(8), .DW(8)) bus ();

  dmem_write_arbiter #(.AW(8), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      mon_got = '{addr: bus.mem_addr, data: bus.mem_data, ack: bus.sw_ack, done: bus.clr_done};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_wr: got addr=%h data=%h ack=%b done=%b, required no write",
                 mon_got.addr, mon_got.data, mon_got.ack, mon_got.done);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          miscompares++;
          $display("FAIL wr: got addr=%h data=%h ack=%b done=%b, required addr=%h data=%h ack=%b done=%b",
                   mon_got.addr, mon_got.data, mon_got.ack, mon_got.done,
                   mon_exp.addr, mon_exp.data, mon_exp.ack, mon_exp.done);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d, input logic ack, input logic done);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.ack  = ack;
    e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] status();
    return {26'd0, bus.mem_we, bus.sw_pending, bus.sw_ack, bus.sw_overflow, bus.clr_busy, bus.clr_done};
  endfunction

  initial begin
    int busy_cnt;
    int done_cyc;
    vectors     = 0;
    miscompares = 0;

    // reset with every request active
    rst = 1'b1;
    bus.pipe_we = 1'b1; bus.pipe_addr = 8'h33; bus.pipe_data = 8'h44;
    bus.sw_req  = 1'b1; bus.sw_addr   = 8'h99; bus.sw_data   = 8'h98;
    bus.clr_start = 1'b1; bus.clr_base = 8'h00; bus.clr_len = 8'h04; bus.clr_value = 8'h77;
    step(); chk("reset_c0", status(), 32'd0);
    step(); chk("reset_c1", status(), 32'd0);
    rst = 1'b0; bus.sw_req = 1'b0; bus.clr_start = 1'b0;
    push(8'h33, 8'h44, 1'b0, 1'b0);
    chk("post_rst_idle", status(), 32'd0);
    step(); chk("first_wr_we", bus.mem_we, 1);
    bus.pipe_we = 1'b0;
    step(); chk("first_wr_busy", bus.clr_busy, 0);
    chk("q_reset", exp_q.size(), 0);

    // pipeline beats a simultaneous switch rise
    bus.pipe_we = 1'b1; bus.pipe_addr = 8'h10; bus.pipe_data = 8'hAA;
    bus.sw_req  = 1'b1; bus.sw_addr   = 8'h20; bus.sw_data   = 8'h55;
    push(8'h10, 8'hAA, 1'b0, 1'b0);
    push(8'h20, 8'h55, 1'b1, 1'b0);
    step(); chk("prio_c1_we_pend", {bus.mem_we, bus.sw_pending}, 2'b11);
    bus.pipe_we = 1'b0;
    step(); chk("prio_c2_ack", {bus.mem_we, bus.sw_ack, bus.sw_pending}, 3'b110);
    bus.sw_req = 1'b0;
    step(); chk("prio_c3_idle", bus.mem_we, 0);
    chk("q_prio", exp_q.size(), 0);

    // second switch rise while the first is still blocked by the pipeline
    for (int c = 0; c < 4; c++) begin
      bus.pipe_we = 1'b1; bus.pipe_addr = 8'h40 + 8'(c); bus.pipe_data = 8'(c);
      bus.sw_req  = (c == 0 || c == 2);
      bus.sw_addr = (c == 0) ? 8'h01 : 8'h02;
      bus.sw_data = (c == 0) ? 8'h11 : 8'h22;
      push(8'h40 + 8'(c), 8'(c), 1'b0, 1'b0);
      step();
      if (c == 0) chk("ovf_c1", {bus.sw_pending, bus.sw_overflow}, 2'b10);
      if (c == 2) chk("ovf_c3", {bus.sw_pending, bus.sw_overflow}, 2'b11);
    end
    bus.pipe_we = 1'b0; bus.sw_req = 1'b0;
    push(8'h01, 8'h11, 1'b1, 1'b0);
    step(); chk("ovf_sw_issue", {bus.mem_we, bus.sw_ack, bus.sw_overflow}, 3'b111);
    step(); chk("ovf_after", {bus.mem_we, bus.sw_pending, bus.sw_overflow}, 3'b001);
    chk("q_ovf", exp_q.size(), 0);

    // fill that wraps past the top address
    bus.clr_base = 8'hFE; bus.clr_len = 8'd3; bus.clr_value = 8'h5A; bus.clr_start = 1'b1;
    push(8'hFE, 8'h5A, 1'b0, 1'b0);
    push(8'hFF, 8'h5A, 1'b0, 1'b0);
    push(8'h00, 8'h5A, 1'b0, 1'b1);
    step(); bus.clr_start = 1'b0;
    chk("wrap_c1", {bus.clr_busy, bus.mem_we}, 2'b10);
    step(); chk("wrap_c2", {bus.mem_we, bus.clr_done}, 2'b10);
    step(); chk("wrap_c3", {bus.mem_we, bus.clr_done}, 2'b10);
    step(); chk("wrap_c4", {bus.mem_we, bus.clr_done, bus.clr_busy}, 3'b111);
    step(); chk("wrap_c5", {bus.mem_we, bus.clr_done, bus.clr_busy}, 3'b000);
    chk("q_wrap", exp_q.size(), 0);

    // full-memory fill with pipeline preemption and an ignored restart
    bus.clr_base = 8'h00; bus.clr_len = 8'h00; bus.clr_value = 8'hC3; bus.clr_start = 1'b1;
    for (int i = 0; i < 10; i++) push(8'(i), 8'hC3, 1'b0, 1'b0);
    push(8'hF0, 8'hE0, 1'b0, 1'b0);
    push(8'hF1, 8'hE1, 1'b0, 1'b0);
    for (int i = 10; i < 256; i++) push(8'(i), 8'hC3, 1'b0, i == 255);
    step();
    busy_cnt = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc < 400 && done_cyc == 0; cyc++) begin
      bus.pipe_we   = (cyc == 11 || cyc == 12);
      bus.pipe_addr = (cyc == 11) ? 8'hF0 : 8'hF1;
      bus.pipe_data = (cyc == 11) ? 8'hE0 : 8'hE1;
      bus.clr_start = (cyc == 20);
      if (cyc == 20) begin
        bus.clr_base = 8'h77; bus.clr_len = 8'd5; bus.clr_value = 8'h99;
      end
      if (bus.clr_busy && !bus.clr_done) busy_cnt++;
      if (bus.clr_done) done_cyc = cyc;
      step();
    end
    bus.pipe_we = 1'b0; bus.clr_start = 1'b0;
    chk("full_busy_cycles", busy_cnt, 258);
    chk("full_done_cycle", done_cyc, 259);
    chk("full_after", {bus.clr_busy, bus.mem_we}, 2'b00);
    chk("q_full", exp_q.size(), 0);

    // reset in the middle of a fill
    bus.clr_base = 8'h30; bus.clr_len = 8'd20; bus.clr_value = 8'h66; bus.clr_start = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 8'h66, 1'b0, 1'b0);
    step(); bus.clr_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("midrst_5th_wr", {bus.mem_we, bus.mem_addr}, {1'b1, 8'h34});
    rst = 1'b1;
    step(); chk("midrst_r0", status(), 32'd0);
    step(); chk("midrst_r1", status(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk("midrst_quiet", status(), 32'd0);
    end
    chk("q_midrst", exp_q.size(), 0);
    bus.clr_base = 8'hA0; bus.clr_len = 8'd2; bus.clr_value = 8'h12; bus.clr_start = 1'b1;
    push(8'hA0, 8'h12, 1'b0, 1'b0);
    push(8'hA1, 8'h12, 1'b0, 1'b1);
    step(); bus.clr_start = 1'b0;
    chk("restart_c1", {bus.clr_busy, bus.mem_we}, 2'b10);
    step(); chk("restart_c2", {bus.mem_we, bus.mem_addr}, {1'b1, 8'hA0});
    step(); chk("restart_c3", {bus.mem_we, bus.clr_done}, 2'b11);
    step(); chk("restart_c4", {bus.clr_busy, bus.mem_we}, 2'b00);
    chk("q_restart", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
